// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath: sequencer state encoding,
// opcode values and operand/result widths.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int W_OPND = 11;
  localparam int W_RES  = 12;

endpackage

// File: rtl/cla.sv
// 4-bit carry-lookahead adder; purely combinational.
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/addsub_seq11.sv
// 11-bit signed add/subtract sequencer: one nibble per cycle through a shared
// cla, carry chained through a register, result published only on completion.
module addsub_seq11
  import calc_pkg::*;
#(
  parameter int NIB = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                OP,
  input  logic [W_OPND-1:0]   A,
  input  logic [W_OPND-1:0]   B,
  output logic                BUSY,
  output logic                DONE,
  output logic [W_RES-1:0]    RESULT,
  output logic                OVF,
  output logic                CARRY
);

  state_e             state_q, state_d;
  logic [1:0]         idx_q, idx_d;
  logic               cry_q, cry_d;
  logic [W_RES-1:0]   ae_q, ae_d;
  logic [W_RES-1:0]   be_q, be_d;
  logic [W_RES-1:0]   shadow_q, shadow_d;
  logic [W_RES-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               carry_out_q, carry_out_d;

  logic [3:0]         nib_a, nib_b, nib_sum;
  logic               nib_cout;

  assign nib_a = ae_q[{idx_q, 2'b00} +: 4];
  assign nib_b = be_q[{idx_q, 2'b00} +: 4];

  cla u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (cry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= calc_pkg::IDLE;
      idx_q       <= 2'd0;
      cry_q       <= 1'b0;
      ae_q        <= '0;
      be_q        <= '0;
      shadow_q    <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      carry_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cry_q       <= cry_d;
      ae_q        <= ae_d;
      be_q        <= be_d;
      shadow_q    <= shadow_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      carry_out_q <= carry_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cry_d       = cry_q;
    ae_d        = ae_q;
    be_d        = be_q;
    shadow_d    = shadow_q;
    result_d    = result_q;
    ovf_d       = ovf_q;
    carry_out_d = carry_out_q;
    unique case (state_q)
      calc_pkg::IDLE, calc_pkg::DONE: begin
        state_d = calc_pkg::IDLE;
        if (START) begin
          // Subtraction is A + ~B + 1: invert B here, the +1 rides in on the carry.
          ae_d    = {A[W_OPND-1], A};
          be_d    = (OP == OP_SUB) ? ~{B[W_OPND-1], B} : {B[W_OPND-1], B};
          cry_d   = OP;
          idx_d   = 2'd0;
          state_d = calc_pkg::RUN;
        end
      end
      calc_pkg::RUN: begin
        shadow_d[{idx_q, 2'b00} +: 4] = nib_sum;
        cry_d = nib_cout;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'(NIB - 1)) begin
          result_d    = {nib_sum, shadow_q[7:0]};
          ovf_d       = nib_sum[3] ^ nib_sum[2];
          carry_out_d = nib_cout;
          state_d     = calc_pkg::DONE;
        end
      end
      default: state_d = calc_pkg::IDLE;
    endcase
  end

  always_comb begin
    BUSY   = (state_q == calc_pkg::RUN);
    DONE   = (state_q == calc_pkg::DONE);
    RESULT = result_q;
    OVF    = ovf_q;
    CARRY  = carry_out_q;
  end

endmodule

// File: tb/tb_addsub_seq11.sv
// Bench for addsub_seq11: directed corner cases then random operations scored
// against a plain-arithmetic reference model.
module tb_addsub_seq11;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [10:0] a;
  logic [10:0] b;
  logic        busy;
  logic        done;
  logic [11:0] result;
  logic        ovf;
  logic        carry;

  int checks;
  int errors;

  // Expected completions, packed as {carry, ovf, result}.
  logic [13:0] exp_q[$];

  addsub_seq11 dut (
    .CLK    (clk),
    .RST    (rst),
    .START  (start),
    .OP     (op),
    .A      (a),
    .B      (b),
    .BUSY   (busy),
    .DONE   (done),
    .RESULT (result),
    .OVF    (ovf),
    .CARRY  (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [13:0] model(input logic [10:0] ma, input logic [10:0] mb,
                                        input logic mop);
    int          sa, sb, r;
    logic [12:0] raw;
    logic        m_ovf;
    sa    = $signed(ma);
    sb    = $signed(mb);
    r     = mop ? (sa - sb) : (sa + sb);
    m_ovf = (r < -1024) || (r > 1023);
    // Raw carry out of bit 11 of the 12-bit unsigned addition actually performed.
    raw   = {1'b0, ma[10], ma} + {1'b0, (mop ? ~{mb[10], mb} : {mb[10], mb})} + 13'(mop);
    return {raw[12], m_ovf, r[11:0]};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: presents one START for a single cycle, returns at the next negedge.
  task automatic issue(input logic [10:0] ia, input logic [10:0] ib, input logic iop);
    start = 1'b1;
    a     = ia;
    b     = ib;
    op    = iop;
    exp_q.push_back(model(ia, ib, iop));
    @(negedge clk);
    start = 1'b0;
    a     = $urandom_range(0, 2047);
    b     = $urandom_range(0, 2047);
    op    = 1'($urandom_range(0, 1));
  endtask

  // Called one negedge after issue: expects BUSY for 3 cycles then the DONE cycle.
  task automatic wait_done(input string tag);
    int          lat;
    logic [13:0] e;
    lat = 0;
    while (!done && lat < 10) begin
      check({tag, "_busy"}, 16'(busy), 16'd1);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 16'(lat), 16'd3);
    check({tag, "_done"}, 16'(done), 16'd1);
    check({tag, "_busy_in_done"}, 16'(busy), 16'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 16'(exp_q.size()), 16'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_result"}, 16'(result), 16'(e[11:0]));
      check({tag, "_ovf"}, 16'(ovf), 16'(e[12]));
      check({tag, "_carry"}, 16'(carry), 16'(e[13]));
    end
  endtask

  initial begin
    logic [13:0] hold;
    int          gap;
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    op     = 1'b0;
    a      = '0;
    b      = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 16'(busy), 16'd0);
    check("reset_done", 16'(done), 16'd0);
    check("reset_result", 16'(result), 16'h000);
    check("reset_ovf", 16'(ovf), 16'd0);
    check("reset_carry", 16'(carry), 16'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(11'd5, 11'h7F9, 1'b0);
    wait_done("add_sign");
    check("add_sign_value", 16'(result), 16'hFFE);
    @(negedge clk);
    check("done_one_cycle", 16'(done), 16'd0);
    check("hold_result", 16'(result), 16'hFFE);

    issue(11'h3FF, 11'd1, 1'b0);
    wait_done("pos_ovf");
    check("pos_ovf_value", 16'({carry, ovf, result}), 16'({1'b0, 1'b1, 12'h400}));
    @(negedge clk);

    issue(11'h400, 11'd1, 1'b1);
    wait_done("sub_ovf");
    check("sub_ovf_value", 16'({carry, ovf, result}), 16'({1'b1, 1'b1, 12'hBFF}));
    @(negedge clk);

    issue(11'h400, 11'h400, 1'b0);
    wait_done("extreme_add");
    check("extreme_add_value", 16'({ovf, result}), 16'({1'b1, 12'h800}));
    issue(11'd3, 11'd3, 1'b1);
    check("b2b_busy", 16'(busy), 16'd1);
    check("b2b_done_once", 16'(done), 16'd0);
    wait_done("b2b");
    check("b2b_value", 16'({carry, ovf, result}), 16'({1'b1, 1'b0, 12'h000}));
    @(negedge clk);

    // START pulsed mid-RUN must be ignored.
    issue(11'd200, 11'd100, 1'b1);
    check("ign_busy0", 16'(busy), 16'd1);
    start = 1'b1;
    a     = 11'd1;
    b     = 11'd1;
    op    = 1'b0;
    @(negedge clk);
    check("ign_busy1", 16'(busy), 16'd1);
    start = 1'b0;
    @(negedge clk);
    check("ign_busy2", 16'(busy), 16'd1);
    @(negedge clk);
    check("ign_busy3", 16'(busy), 16'd0);
    check("ign_done", 16'(done), 16'd1);
    check("ign_result", 16'(result), 16'h064);
    void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ign_single_done", 16'(done), 16'd0);
      check("ign_idle_busy", 16'(busy), 16'd0);
    end

    // Reset mid-RUN abandons the operation.
    issue(11'd100, 11'd50, 1'b0);
    void'(exp_q.pop_front());
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("rst_mid_done", 16'(done), 16'd0);
      check("rst_mid_busy", 16'(busy), 16'd0);
      check("rst_mid_result", 16'(result), 16'h000);
      check("rst_mid_ovf", 16'(ovf), 16'd0);
      @(negedge clk);
    end

    // Random operations, sometimes back-to-back from the DONE cycle.
    for (int n = 0; n < 60; n++) begin
      issue(11'($urandom_range(0, 2047)), 11'($urandom_range(0, 2047)),
            1'($urandom_range(0, 1)));
      wait_done("rand");
      hold = {carry, ovf, result};
      gap  = $urandom_range(0, 3);
      if (gap != 0) begin
        for (int g = 0; g < gap; g++) begin
          @(negedge clk);
          check("rand_hold", 16'({carry, ovf, result}), 16'(hold));
          check("rand_idle_done", 16'(done), 16'd0);
        end
      end
    end

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
